// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS general-purpose register file on the writeback path.
//  - One synchronous write port (WB stage), two combinational read ports (ID stage).
//  - Register 0 is hardwired to zero.
//  - Serial dump engine streams every register over a valid/ready handshake.
// Optional feature, enabled by defining REG_FILE_BYPASS_EN:
//  - Write-before-read forwarding on both read ports and on the dump capture.
module reg_file_wb #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_reg_write_W,
  input  logic [NB_ADDR-1:0] i_write_reg_W,
  input  logic [NB_DATA-1:0] i_write_data_W,
  input  logic [NB_ADDR-1:0] i_read_reg_a_D,
  input  logic [NB_ADDR-1:0] i_read_reg_b_D,
  output logic [NB_DATA-1:0] o_read_data_a_D,
  output logic [NB_DATA-1:0] o_read_data_b_D,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last,
  output logic               o_dump_busy
);

  localparam int N_REGS = 2 ** NB_ADDR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  logic [NB_DATA-1:0] regs [N_REGS];

  logic               wr_en;
  logic [NB_DATA-1:0] rd_a;
  logic [NB_DATA-1:0] rd_b;
  logic [NB_DATA-1:0] cap_data;

  state_t             state;
  state_t             state_n;
  logic [NB_ADDR-1:0] idx;
  logic [NB_ADDR-1:0] idx_n;

  logic               vld_p1;
  logic               vld_n;
  logic [NB_ADDR-1:0] dump_addr_p1;
  logic [NB_ADDR-1:0] addr_n;
  logic [NB_DATA-1:0] dump_data_p1;
  logic [NB_DATA-1:0] data_n;
  logic               dump_last_p1;
  logic               last_n;

  // A write to register 0 is dropped here, so regs[0] only ever holds zero.
  assign wr_en = i_reg_write_W && (i_write_reg_W != '0);

  // Register array: cleared on reset, written at the edge after WB presents data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[i_write_reg_W] <= i_write_data_W;
    end
  end

  // Read ports and dump capture source; address 0 always reads zero.
  always_comb begin
    rd_a     = (i_read_reg_a_D == '0) ? '0 : regs[i_read_reg_a_D];
    rd_b     = (i_read_reg_b_D == '0) ? '0 : regs[i_read_reg_b_D];
    cap_data = (idx == '0) ? '0 : regs[idx];
`ifdef REG_FILE_BYPASS_EN
    // wr_en already excludes address 0, so the zero rule still holds here.
    if (wr_en && (i_read_reg_a_D == i_write_reg_W)) rd_a = i_write_data_W;
    if (wr_en && (i_read_reg_b_D == i_write_reg_W)) rd_b = i_write_data_W;
    if (wr_en && (idx == i_write_reg_W))            cap_data = i_write_data_W;
`endif
  end

  assign o_read_data_a_D = rd_a;
  assign o_read_data_b_D = rd_b;

  // Dump engine next-state: LOAD captures one register, SEND holds it until accepted.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    vld_n   = vld_p1;
    addr_n  = dump_addr_p1;
    data_n  = dump_data_p1;
    last_n  = dump_last_p1;
    case (state)
      IDLE: begin
        if (i_dump_start) begin
          idx_n   = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        addr_n  = idx;
        data_n  = cap_data;
        vld_n   = 1'b1;
        last_n  = &idx;
        state_n = SEND;
      end
      SEND: begin
        // Beat fields are frozen here; later writes to the array do not reach them.
        if (vld_p1 && i_dump_ready) begin
          vld_n = 1'b0;
          if (dump_last_p1) begin
            last_n  = 1'b0;
            state_n = IDLE;
          end else begin
            idx_n   = idx + NB_ADDR'(1);
            state_n = LOAD;
          end
        end
      end
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
        last_n  = 1'b0;
      end
    endcase
  end

  // ---- stage p1: registered dump beat; reset aborts any dump in progress ----
  // Dump engine state and beat registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      idx          <= '0;
      vld_p1       <= 1'b0;
      dump_addr_p1 <= '0;
      dump_data_p1 <= '0;
      dump_last_p1 <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      vld_p1       <= vld_n;
      dump_addr_p1 <= addr_n;
      dump_data_p1 <= data_n;
      dump_last_p1 <= last_n;
    end
  end

  assign o_dump_valid = vld_p1;
  assign o_dump_addr  = dump_addr_p1;
  assign o_dump_data  = dump_data_p1;
  assign o_dump_last  = dump_last_p1;
  assign o_dump_busy  = (state != IDLE);

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed self-checking bench for reg_file_wb.
// Expected values are hand-computed; REG_FILE_BYPASS_EN selects the
// same-cycle read expectation when the design is built with forwarding.
module tb_reg_file_wb;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;

  logic               clk;
  logic               reset;
  logic               reg_write;
  logic [NB_ADDR-1:0] write_reg;
  logic [NB_DATA-1:0] write_data;
  logic [NB_ADDR-1:0] read_a;
  logic [NB_ADDR-1:0] read_b;
  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic               dump_start;
  logic               dump_ready;
  logic               dump_valid;
  logic [NB_ADDR-1:0] dump_addr;
  logic [NB_DATA-1:0] dump_data;
  logic               dump_last;
  logic               dump_busy;

  int passed;
  int total;

  reg_file_wb #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_reg_write_W   (reg_write),
    .i_write_reg_W   (write_reg),
    .i_write_data_W  (write_data),
    .i_read_reg_a_D  (read_a),
    .i_read_reg_b_D  (read_b),
    .o_read_data_a_D (data_a),
    .o_read_data_b_D (data_b),
    .i_dump_start    (dump_start),
    .i_dump_ready    (dump_ready),
    .o_dump_valid    (dump_valid),
    .o_dump_addr     (dump_addr),
    .o_dump_data     (dump_data),
    .o_dump_last     (dump_last),
    .o_dump_busy     (dump_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next dump beat; an expired bound shows up as a failed check.
  task automatic wait_valid();
    for (int k = 0; k < 8 && !dump_valid; k++) tick();
    chk("dump_valid_wait", 32'(dump_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_same;
    passed = 0;
    total  = 0;
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_a = '0; read_b = '0; dump_start = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state: dump outputs idle, every register reads zero on both ports.
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy",  32'(dump_busy),  32'd0);
    chk("rst_last",  32'(dump_last),  32'd0);
    chk("rst_addr",  32'(dump_addr),  32'd0);
    chk("rst_data",  dump_data,       32'd0);
    for (int i = 0; i < 32; i++) begin
      read_a = NB_ADDR'(i);
      read_b = NB_ADDR'(31 - i);
      #1;
      chk("rst_read_a", data_a, 32'd0);
      chk("rst_read_b", data_b, 32'd0);
    end

    // Plain write then read one cycle later.
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    tick();
    reg_write = 1'b0; read_a = 5'd5; read_b = 5'd5;
    #1;
    chk("r5_a", data_a, 32'hDEADBEEF);
    chk("r5_b", data_b, 32'hDEADBEEF);

    // Write to r0 is discarded, also during the write cycle itself.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678; read_a = 5'd0;
    #1;
    chk("r0_same_cycle", data_a, 32'd0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("r0_after", data_a, 32'd0);

    // Same-cycle write/read of r7.
`ifdef REG_FILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'd0;
`endif
    reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hA5A5A5A5; read_a = 5'd7;
    #1;
    chk("r7_same_cycle", data_a, exp_same);
    tick();
    reg_write = 1'b0;
    #1;
    chk("r7_next_cycle", data_a, 32'hA5A5A5A5);

    // Preload rN = N*0x11.
    for (int n = 1; n < 32; n++) begin
      reg_write = 1'b1; write_reg = NB_ADDR'(n); write_data = 32'(n * 17);
      tick();
    end
    reg_write = 1'b0;

    // Full dump with ready held high.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_ready = 1'b1;
    chk("dump_busy_start", 32'(dump_busy), 32'd1);
    chk("dump_valid_load", 32'(dump_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      wait_valid();
      chk("dump_addr", 32'(dump_addr), 32'(i));
      chk("dump_data", dump_data, 32'(i * 17));
      chk("dump_last", 32'(dump_last), (i == 31) ? 32'd1 : 32'd0);
      tick();
    end
    chk("dump_end_busy",  32'(dump_busy),  32'd0);
    chk("dump_end_valid", 32'(dump_valid), 32'd0);
    dump_ready = 1'b0;

    // Second dump: stall on beat 3 while r3 is rewritten and start is re-pulsed.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid();
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
    end
    wait_valid();
    chk("stall_addr0", 32'(dump_addr), 32'd3);
    chk("stall_data0", dump_data, 32'h33);
    for (int c = 0; c < 5; c++) begin
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hFFFF0000; dump_start = 1'b1;
      tick();
      chk("stall_valid", 32'(dump_valid), 32'd1);
      chk("stall_addr",  32'(dump_addr),  32'd3);
      chk("stall_data",  dump_data,       32'h33);
      chk("stall_busy",  32'(dump_busy),  32'd1);
    end
    reg_write = 1'b0; dump_start = 1'b0; read_a = 5'd3;
    #1;
    chk("r3_written", data_a, 32'hFFFF0000);
    dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    wait_valid();
    chk("after_stall_addr", 32'(dump_addr), 32'd4);
    chk("after_stall_data", dump_data, 32'h44);

    // Continue to beat 10, then reset mid-dump.
    for (int i = 4; i < 10; i++) begin
      wait_valid();
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
    end
    wait_valid();
    chk("beat10_addr", 32'(dump_addr), 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy",  32'(dump_busy),  32'd0);
    for (int i = 0; i < 32; i++) begin
      read_a = NB_ADDR'(i);
      #1;
      chk("abort_clear", data_a, 32'd0);
    end
    dump_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_beat", 32'(dump_valid), 32'd0);
    end

    // Reset wins over a simultaneous start.
    reset = 1'b1; dump_start = 1'b1;
    tick();
    reset = 1'b0; dump_start = 1'b0;
    chk("rst_vs_start_busy", 32'(dump_busy), 32'd0);
    tick();
    chk("rst_vs_start_valid", 32'(dump_valid), 32'd0);

    // A fresh dump restarts from address 0 with cleared contents.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    wait_valid();
    chk("restart_addr0", 32'(dump_addr), 32'd0);
    chk("restart_data0", dump_data, 32'd0);
    tick();
    wait_valid();
    chk("restart_addr1", 32'(dump_addr), 32'd1);
    chk("restart_data1", dump_data, 32'd0);
    dump_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
